// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a producer, the serializer and the serial detector.
// load/ready handshake: a word transfers at a rising edge where load=1 and ready=1; din is only sampled then.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output din, load,
        input  ready, x, x_valid, word_done, busy
    );

    modport slave (
        input  din, load,
        output ready, x, x_valid, word_done, busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-in, serial-out stage: streams WIDTH-bit words onto x one bit per clock,
// chaining back-to-back words with no idle gap so patterns can span word boundaries.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    seq_serializer_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_word_done;

    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sr_adv;
    logic [WIDTH-1:0] w_sr_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_x_n;
    logic             w_x_valid_n;
    logic             w_word_done_n;

    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_ready  = !RESET && ((r_state == S_IDLE) || (r_state == S_SHIFT && w_last));
    assign w_accept = bus.load && w_ready;
    // Bit just sent drops off the leading end; the next one becomes the leading bit.
    assign w_sr_adv = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_n = w_accept ? S_SHIFT : S_IDLE;
            S_SHIFT: w_state_n = (!w_last || w_accept) ? S_SHIFT : S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // A load on the last bit takes the accept branch, so the new word follows with no bubble.
    always_comb begin
        w_sr_n        = r_sr;
        w_cnt_n       = r_cnt;
        w_x_n         = 1'b0;
        w_x_valid_n   = 1'b0;
        w_word_done_n = 1'b0;
        if (w_accept) begin
            w_sr_n      = bus.din;
            w_cnt_n     = '0;
            w_x_n       = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
            w_x_valid_n = 1'b1;
        end else if (r_state == S_SHIFT && !w_last) begin
            w_sr_n        = w_sr_adv;
            w_cnt_n       = r_cnt + CNT_W'(1);
            w_x_n         = MSB_FIRST ? w_sr_adv[WIDTH-1] : w_sr_adv[0];
            w_x_valid_n   = 1'b1;
            w_word_done_n = (r_cnt == CNT_W'(WIDTH - 2));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_x         <= 1'b0;
            r_x_valid   <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_sr        <= w_sr_n;
            r_cnt       <= w_cnt_n;
            r_x         <= w_x_n;
            r_x_valid   <= w_x_valid_n;
            r_word_done <= w_word_done_n;
        end
    end

    assign bus.ready     = w_ready;
    assign bus.x         = r_x;
    assign bus.x_valid   = r_x_valid;
    assign bus.word_done = r_word_done;
    assign bus.busy      = (r_state == S_SHIFT);
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an 8-bit MSB-first and a 4-bit LSB-first instance share one
// input stream; both are checked every cycle against a bit-queue model, plus directed vectors.
module tb_seq_serializer;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    seq_serializer_if #(.WIDTH(8)) bus8 ();
    seq_serializer_if #(.WIDTH(4)) bus4 ();

    assign bus8.load = load;
    assign bus8.din  = din;
    assign bus4.load = load;
    assign bus4.din  = din[3:0];

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus8.slave)
    );

    seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus4.slave)
    );

    // Reference: a queue holding the bits still to appear on x, head = bit on x now.
    logic exp_q8[$];
    logic exp_q4[$];

    always @(posedge CLK) begin : model8
        bit acc;
        acc = !RESET && load && (exp_q8.size() <= 1);
        if (RESET) begin
            exp_q8.delete();
        end else begin
            if (exp_q8.size() > 0) exp_q8.delete(0);
            if (acc) for (int i = 0; i < 8; i++) exp_q8.push_back(din[7-i]);
        end
    end

    always @(posedge CLK) begin : model4
        bit acc;
        acc = !RESET && load && (exp_q4.size() <= 1);
        if (RESET) begin
            exp_q4.delete();
        end else begin
            if (exp_q4.size() > 0) exp_q4.delete(0);
            if (acc) for (int i = 0; i < 4; i++) exp_q4.push_back(din[i]);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m8_x",     bus8.x,         exp_q8.size() > 0 ? exp_q8[0] : 1'b0);
        chk("m8_valid", bus8.x_valid,   exp_q8.size() > 0);
        chk("m8_done",  bus8.word_done, exp_q8.size() == 1);
        chk("m8_ready", bus8.ready,     !RESET && exp_q8.size() <= 1);
        chk("m8_busy",  bus8.busy,      exp_q8.size() > 0);
        chk("m4_x",     bus4.x,         exp_q4.size() > 0 ? exp_q4[0] : 1'b0);
        chk("m4_valid", bus4.x_valid,   exp_q4.size() > 0);
        chk("m4_done",  bus4.word_done, exp_q4.size() == 1);
        chk("m4_ready", bus4.ready,     !RESET && exp_q4.size() <= 1);
        chk("m4_busy",  bus4.busy,      exp_q4.size() > 0);
    endtask

    // Drive one cycle's inputs away from the edge, then check what is visible in that cycle.
    task automatic step(input logic r, input logic l, input logic [7:0] d);
        @(negedge CLK);
        RESET = r;
        load  = l;
        din   = d;
        #1;
        check_model();
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] d;
        logic       x;
        logic       xv;
        logic       done;
        logic       rdy;
        logic       busy;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [7:0] pat;

        // 8'hD5 then 8'h3C back to back, second load held from the cycle after the first.
        tbl[0]  = '{1'b1, 8'hD5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge CLK);

        // Reset state, first cycle out of reset.
        step(1'b0, 1'b0, 8'h00);
        chk("rst_x8",    bus8.x,       1'b0);
        chk("rst_busy8", bus8.busy,    1'b0);
        chk("rst_rdy8",  bus8.ready,   1'b1);

        for (int i = 0; i < 18; i++) begin
            step(1'b0, tbl[i].ld, tbl[i].d);
            chk("tbl_x",     bus8.x,         tbl[i].x);
            chk("tbl_valid", bus8.x_valid,   tbl[i].xv);
            chk("tbl_done",  bus8.word_done, tbl[i].done);
            chk("tbl_ready", bus8.ready,     tbl[i].rdy);
            chk("tbl_busy",  bus8.busy,      tbl[i].busy);
        end

        // LSB-first 4'b1011, with a 4'hF load pulsed mid-word that must be ignored.
        step(1'b0, 1'b1, 8'h0B);
        step(1'b0, 1'b0, 8'h00);
        chk("lsb_b0", bus4.x, 1'b1);
        step(1'b0, 1'b1, 8'hFF);
        chk("lsb_b1", bus4.x, 1'b1);
        chk("lsb_busy_rdy", bus4.ready, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("lsb_b2", bus4.x, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("lsb_b3", bus4.x, 1'b1);
        chk("lsb_done", bus4.word_done, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("lsb_no_f", bus4.x_valid, 1'b0);
        end

        // Reset in the middle of 8'hFF, then 8'h0D must come out clean.
        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        chk("mid_x", bus8.x, 1'b1);
        step(1'b1, 1'b0, 8'h00);
        chk("rst_rdy_low", bus8.ready, 1'b0);
        step(1'b0, 1'b0, 8'h00);
        chk("post_rst_x",    bus8.x,         1'b0);
        chk("post_rst_v",    bus8.x_valid,   1'b0);
        chk("post_rst_busy", bus8.busy,      1'b0);
        chk("post_rst_done", bus8.word_done, 1'b0);
        step(1'b0, 1'b1, 8'h0D);
        pat = 8'h0D;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("clean_bit",   bus8.x,       pat[7-i]);
            chk("clean_valid", bus8.x_valid, 1'b1);
        end

        // Load coinciding with reset is not accepted.
        step(1'b1, 1'b1, 8'hAA);
        chk("rl_ready", bus8.ready, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00);
            chk("rl_x",     bus8.x,       1'b0);
            chk("rl_valid", bus8.x_valid, 1'b0);
        end

        // Random traffic with occasional resets, checked against the queue model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        step(1'b0, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the serial sequence detector.
- Accepts WIDTH-bit words through a valid/ready handshake and drives them out one bit per clock on x.
- Back-to-back words stream with no idle gap, so a pattern that spans a word boundary stays contiguous on the serial line.
- Drives x low when idle and flags the bits it is driving with x_valid.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- load  input  1  word-valid request from the producer.
- ready  output  1  stage can accept a word this cycle.
- x  output  1  serial bit to the detector; registered.
- x_valid  output  1  high while x carries a data bit; registered.
- word_done  output  1  one-cycle pulse in the cycle the last bit of a word is on x; registered.
- busy  output  1  high while the state is SHIFT.

Behaviour:
- State machine has two states, IDLE and SHIFT.
- Internal storage: shift register sr[WIDTH-1:0] and bit counter cnt, ceil(log2 WIDTH) bits wide.
- Accept rule: a word is accepted at a rising edge where load=1 and ready=1. load while ready=0 is ignored; din is not captured.
- ready is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when cnt==WIDTH-1 (last bit on x).
  - 0 otherwise.
  - Forced to 0 while RESET=1.
- Latency: a word accepted at edge k puts its first bit on x in the cycle after edge k. Its last bit is on x in the cycle after edge k+WIDTH-1.
- On accept from IDLE:
  - sr <= din.
  - x <= first bit: din[WIDTH-1] if MSB_FIRST, else din[0].
  - x_valid <= 1, cnt <= 0, state <= SHIFT.
- In SHIFT with cnt<WIDTH-1:
  - x <= next bit in order; cnt <= cnt+1.
  - The shift direction follows MSB_FIRST; vacated bits fill with 0.
- In SHIFT with cnt==WIDTH-1:
  - word_done is 1 in this cycle. It is registered, so it is asserted by the same edge that loaded the last bit.
  - If load=1 at this edge: the new word is accepted exactly as from IDLE, staying in SHIFT with cnt <= 0. The new word's first bit directly follows the old word's last bit, with no gap and no x=0 bubble.
  - If load=0: state <= IDLE, x <= 0, x_valid <= 0.
- In IDLE with no accepted load, x=0 and x_valid=0. The downstream detector samples x every cycle, so idle zeros reset a partial pattern. This is intended.
- Reset (RESET=1 at an edge) takes priority over everything:
  - state <= IDLE, sr <= 0, cnt <= 0.
  - x, x_valid, word_done, busy all <= 0.
  - A word in flight is discarded, with no partial-word output after reset.
  - A load in the same cycle as RESET is not accepted.
- busy = (state==SHIFT).
- word_done never asserts without x_valid=1.
- Any unreachable state encoding recovers to IDLE on the next edge.

Test Plan:
- WIDTH=4, MSB_FIRST=1, load din=4'b1101 at edge k, idle otherwise -> cycles k+1..k+4 show x=1,1,0,1 and x_valid=1. word_done=1 only at k+4. Cycle k+5 shows x=0, x_valid=0, ready=1. Connected detector gives y=1 in cycle k+4.
- WIDTH=8, MSB_FIRST=1, back-to-back loads 8'hD5 then 8'h3C, the second load held until accepted -> 16 consecutive x_valid cycles with x=1,1,0,1,0,1,0,1,0,0,1,1,1,1,0,0. ready=1 only at the cycles with cnt==7. word_done pulses at bit 8 and bit 16.
- WIDTH=4, MSB_FIRST=0, din=4'b1011 -> x=1,1,0,1. Pulse load=1 with din=4'hF during bit 2 -> ignored; the 4'hF word is never output.
- WIDTH=8, reset at bit 3 of 8'hFF -> next cycle x=0, x_valid=0, busy=0, word_done=0. Next word 8'h0D loaded after reset outputs 0,0,0,0,1,1,0,1 with no residue of 8'hFF.
- RESET=1 and load=1 in the same cycle with din=8'hAA -> no accept. x stays 0 for the following 8 cycles, and ready=0 during the reset cycle.
